// File: rtl/dmem_pkg.sv
// Shared types and constants for the data memory responder and its requesters.
package dmem_pkg;

  localparam int unsigned DataWidth = 32;

  // Instruction IDs the requester maps onto req_we.
  localparam int unsigned LW_ID = 13;
  localparam int unsigned SW_ID = 14;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StWait = 2'd1,
    StResp = 2'd2
  } state_e;

  // Store instructions drive req_we high; everything else is treated as a load.
  function automatic logic id_is_store(input int unsigned id);
    return id == SW_ID;
  endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Request/response channel between the load/store path and the data memory.
interface data_mem_responder_if;
  import dmem_pkg::*;

  logic                 req_valid;
  logic                 req_ready;
  logic                 req_we;
  logic [DataWidth-1:0] req_addr;
  logic [DataWidth-1:0] req_wdata;
  logic                 resp_valid;
  logic                 resp_ready;
  logic [DataWidth-1:0] resp_rdata;
  logic                 resp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );

endinterface

// File: rtl/dmem_array.sv
// Single-port word RAM: synchronous write, combinational read, no reset.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH     = 256,
  parameter int unsigned AddrWidth = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [AddrWidth-1:0] addr,
  input  logic [DataWidth-1:0] wdata,
  output logic [DataWidth-1:0] rdata
);

  logic [DataWidth-1:0] mem [DEPTH];

  // Write port.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/data_mem_responder.sv
// Data memory responder: accepts one lw/sw request, waits LATENCY cycles,
// commits to the array and holds a single registered response until taken.
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH   = 256,
  parameter int unsigned LATENCY = 2
) (
  input logic                 clk,
  input logic                 reset,
  data_mem_responder_if.slave bus
);

  localparam int unsigned AddrWidth = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0]  CntLoad   = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;

  state_e               state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic                 we_q, we_d;
  logic [DataWidth-1:0] addr_q, addr_d;
  logic [DataWidth-1:0] wdata_q, wdata_d;
  logic                 resp_valid_q, resp_valid_d;
  logic [DataWidth-1:0] resp_rdata_q, resp_rdata_d;
  logic                 resp_err_q, resp_err_d;

  // Commit source: the live request when LATENCY is 0, otherwise the latches.
  logic                 commit;
  logic                 c_we;
  logic [DataWidth-1:0] c_addr;
  logic [DataWidth-1:0] c_wdata;
  logic                 in_range;

  logic                 mem_we;
  logic [DataWidth-1:0] mem_rdata;

  // State, counter, request latches and response registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_rdata_q <= '0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  // Next-state, wait countdown, commit decision and response capture.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    resp_valid_d = resp_valid_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    commit       = 1'b0;
    c_we         = we_q;
    c_addr       = addr_q;
    c_wdata      = wdata_q;

    unique case (state_q)
      StIdle: begin
        if (bus.req_valid) begin
          we_d    = bus.req_we;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          if (LATENCY == 0) begin
            commit  = 1'b1;
            c_we    = bus.req_we;
            c_addr  = bus.req_addr;
            c_wdata = bus.req_wdata;
          end else begin
            state_d = StWait;
            cnt_d   = CntLoad;
          end
        end
      end
      StWait: begin
        if (cnt_q == '0) begin
          commit = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StResp: begin
        if (bus.resp_ready) begin
          state_d      = StIdle;
          resp_valid_d = 1'b0;
          resp_rdata_d = '0;
          resp_err_d   = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase

    // Full-width unsigned compare so aliased high addresses never hit the array.
    in_range = c_addr < DataWidth'(DEPTH);

    if (commit) begin
      state_d      = StResp;
      resp_valid_d = 1'b1;
      resp_err_d   = ~in_range;
      resp_rdata_d = (in_range && !c_we) ? mem_rdata : '0;
    end
  end

  assign mem_we = commit && c_we && in_range;

  dmem_array #(
    .DEPTH     (DEPTH),
    .AddrWidth (AddrWidth)
  ) u_array (
    .clk   (clk),
    .we    (mem_we),
    .addr  (c_addr[AddrWidth-1:0]),
    .wdata (c_wdata),
    .rdata (mem_rdata)
  );

  assign bus.req_ready  = (state_q == StIdle);
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.resp_err   = resp_err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: transaction-level model plus directed and random traffic.
module tb_data_mem_responder;
  import dmem_pkg::*;

  localparam int unsigned Depth = 256;
  localparam int unsigned Lat   = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  data_mem_responder_if bus2 ();
  data_mem_responder_if bus0 ();

  data_mem_responder #(.DEPTH(Depth), .LATENCY(Lat)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus2)
  );

  data_mem_responder #(.DEPTH(Depth), .LATENCY(0)) dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus0)
  );

  int tests = 0;
  int fails = 0;
  bit chk_on = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction model of the LATENCY=2 instance: one request in flight, memory
  // updated LATENCY edges after acceptance, response held until taken.
  bit          m_busy = 1'b0;
  int          m_age = 0;
  bit          m_we;
  logic [31:0] m_addr, m_wdata;
  bit          m_valid = 1'b0;
  logic [31:0] m_rdata = '0;
  bit          m_err = 1'b0;
  logic [31:0] m_mem [Depth];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_busy  <= 1'b0;
      m_age   <= 0;
      m_valid <= 1'b0;
      m_rdata <= '0;
      m_err   <= 1'b0;
    end else if (!m_busy) begin
      if (bus2.req_valid) begin
        m_busy  <= 1'b1;
        m_age   <= 0;
        m_we    <= bus2.req_we;
        m_addr  <= bus2.req_addr;
        m_wdata <= bus2.req_wdata;
      end
    end else if (m_valid) begin
      if (bus2.resp_ready) begin
        m_busy  <= 1'b0;
        m_valid <= 1'b0;
        m_rdata <= '0;
        m_err   <= 1'b0;
      end
    end else begin
      m_age <= m_age + 1;
      if (m_age + 1 == Lat) begin
        m_valid <= 1'b1;
        if (m_addr >= Depth) begin
          m_err   <= 1'b1;
          m_rdata <= '0;
        end else if (m_we) begin
          m_mem[m_addr[7:0]] <= m_wdata;
          m_err   <= 1'b0;
          m_rdata <= '0;
        end else begin
          m_err   <= 1'b0;
          m_rdata <= m_mem[m_addr[7:0]];
        end
      end
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    if (!reset && chk_on) begin
      check("req_ready",  32'(bus2.req_ready),  32'(!m_busy));
      check("resp_valid", 32'(bus2.resp_valid), 32'(m_valid));
      check("resp_rdata", bus2.resp_rdata,      m_rdata);
      check("resp_err",   32'(bus2.resp_err),   32'(m_err));
    end
  end

  // One request on the LATENCY=2 instance. Called just after a rising edge.
  // lat counts falling edges from the accepting edge until resp_valid is seen.
  // With hold set, resp_ready stays low and the task returns in RESP.
  task automatic req2(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                      input bit hold, output int lat, output logic [31:0] rd,
                      output logic err);
    int n;
    bus2.req_valid  = 1'b1;
    bus2.req_we     = we;
    bus2.req_addr   = addr;
    bus2.req_wdata  = wd;
    bus2.resp_ready = !hold;
    n = 0;
    @(negedge clk);
    while (!bus2.req_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (n >= 50) check("accept_timeout", 32'(n), 32'd0);
    @(posedge clk);
    #1;
    bus2.req_valid = 1'b0;
    lat = 0;
    while (lat < 50) begin
      @(negedge clk);
      lat++;
      check("busy_ready_low", 32'(bus2.req_ready), 32'd0);
      if (bus2.resp_valid) break;
    end
    rd  = bus2.resp_rdata;
    err = bus2.resp_err;
    if (!hold) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One request on the LATENCY=0 instance, same timing conventions as req2.
  task automatic req0(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                      output int lat, output logic [31:0] rd, output logic err);
    bus0.req_valid  = 1'b1;
    bus0.req_we     = we;
    bus0.req_addr   = addr;
    bus0.req_wdata  = wd;
    bus0.resp_ready = 1'b1;
    @(negedge clk);
    check("l0_ready", 32'(bus0.req_ready), 32'd1);
    @(posedge clk);
    #1;
    bus0.req_valid = 1'b0;
    lat = 0;
    while (lat < 50) begin
      @(negedge clk);
      lat++;
      if (bus0.resp_valid) break;
    end
    rd  = bus0.resp_rdata;
    err = bus0.resp_err;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("l0_back_idle", 32'(bus0.req_ready), 32'd1);
    @(posedge clk);
    #1;
  endtask

  logic [31:0] pre [Depth];

  initial begin
    int lat;
    logic [31:0] rd;
    logic err;
    int r;

    bus2.req_valid = 1'b0; bus2.req_we = 1'b0; bus2.req_addr = '0; bus2.req_wdata = '0;
    bus2.resp_ready = 1'b1;
    bus0.req_valid = 1'b0; bus0.req_we = 1'b0; bus0.req_addr = '0; bus0.req_wdata = '0;
    bus0.resp_ready = 1'b1;

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_req_ready",  32'(bus2.req_ready),  32'd1);
    check("rst_resp_valid", 32'(bus2.resp_valid), 32'd0);
    check("rst_resp_rdata", bus2.resp_rdata,      32'd0);
    check("rst_resp_err",   32'(bus2.resp_err),   32'd0);
    check("rst0_req_ready", 32'(bus0.req_ready),  32'd1);
    @(posedge clk);
    #1;
    reset  = 1'b0;
    chk_on = 1'b1;

    // Fill every word so later loads have defined contents.
    for (int i = 0; i < Depth; i++) begin
      pre[i] = $urandom;
      req2(1'b1, 32'(i), pre[i], 1'b0, lat, rd, err);
    end

    // Store then load.
    req2(id_is_store(SW_ID), 32'd110, 32'd100, 1'b0, lat, rd, err);
    check("st110_lat", 32'(lat), 32'd3);
    check("st110_rdata", rd, 32'd0);
    check("st110_err", 32'(err), 32'd0);
    req2(id_is_store(LW_ID), 32'd110, 32'd0, 1'b0, lat, rd, err);
    check("ld110_lat", 32'(lat), 32'd3);
    check("ld110_rdata", rd, 32'd100);
    check("ld110_err", 32'(err), 32'd0);

    req2(1'b1, 32'd22, 32'hDEADBEEF, 1'b0, lat, rd, err);
    req2(1'b0, 32'd22, 32'd0, 1'b0, lat, rd, err);
    check("ld22_lat", 32'(lat), 32'd3);
    check("ld22_rdata", rd, 32'hDEADBEEF);
    check("ld22_err", 32'(err), 32'd0);

    // Out of range, with the aliased in-range word untouched.
    req2(1'b1, 32'd44, 32'h1234_0044, 1'b0, lat, rd, err);
    req2(1'b1, 32'd300, 32'd55, 1'b0, lat, rd, err);
    check("st300_err", 32'(err), 32'd1);
    check("st300_rdata", rd, 32'd0);
    req2(1'b0, 32'd300, 32'd0, 1'b0, lat, rd, err);
    check("ld300_err", 32'(err), 32'd1);
    check("ld300_rdata", rd, 32'd0);
    req2(1'b0, 32'd44, 32'd0, 1'b0, lat, rd, err);
    check("ld44_rdata", rd, 32'h1234_0044);
    check("ld44_err", 32'(err), 32'd0);
    req2(1'b0, 32'd256, 32'd0, 1'b0, lat, rd, err);
    check("ld256_err", 32'(err), 32'd1);
    req2(1'b0, 32'hFFFF_FFFF, 32'd0, 1'b0, lat, rd, err);
    check("ldmax_err", 32'(err), 32'd1);
    req2(1'b0, 32'd255, 32'd0, 1'b0, lat, rd, err);
    check("ld255_err", 32'(err), 32'd0);
    check("ld255_rdata", rd, pre[255]);

    // Backpressure: response held five cycles, a stray request is ignored.
    req2(1'b0, 32'd22, 32'd0, 1'b1, lat, rd, err);
    check("bp_first_rdata", rd, 32'hDEADBEEF);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      bus2.req_valid = (k == 1);
      bus2.req_we    = 1'b1;
      bus2.req_addr  = 32'd5;
      bus2.req_wdata = 32'd77;
      @(negedge clk);
      check("bp_valid", 32'(bus2.resp_valid), 32'd1);
      check("bp_rdata", bus2.resp_rdata, 32'hDEADBEEF);
      check("bp_err", 32'(bus2.resp_err), 32'd0);
      check("bp_ready", 32'(bus2.req_ready), 32'd0);
    end
    @(posedge clk);
    #1;
    bus2.resp_ready = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    check("bp_idle_ready", 32'(bus2.req_ready), 32'd1);
    check("bp_idle_valid", 32'(bus2.resp_valid), 32'd0);
    @(posedge clk);
    #1;
    req2(1'b0, 32'd5, 32'd0, 1'b0, lat, rd, err);
    check("ld5_unchanged", rd, pre[5]);

    // Reset one cycle after accepting a store: the store must never land.
    req2(1'b1, 32'd7, 32'd1, 1'b0, lat, rd, err);
    bus2.req_valid = 1'b1;
    bus2.req_we    = 1'b1;
    bus2.req_addr  = 32'd7;
    bus2.req_wdata = 32'd9;
    @(negedge clk);
    check("rw_accept_ready", 32'(bus2.req_ready), 32'd1);
    @(posedge clk);
    #1;
    bus2.req_valid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("rw_req_ready",  32'(bus2.req_ready),  32'd1);
    check("rw_resp_valid", 32'(bus2.resp_valid), 32'd0);
    check("rw_resp_rdata", bus2.resp_rdata,      32'd0);
    check("rw_resp_err",   32'(bus2.resp_err),   32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    req2(1'b0, 32'd7, 32'd0, 1'b0, lat, rd, err);
    check("ld7_after_reset", rd, 32'd1);

    // Random traffic, including requests while busy and response backpressure.
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk);
      #1;
      bus2.req_valid = ($urandom % 3) == 0;
      bus2.req_we    = $urandom % 2;
      r = $urandom % 16;
      if (r == 0)      bus2.req_addr = 32'(Depth) + ($urandom % 64);
      else if (r == 1) bus2.req_addr = $urandom;
      else if (r == 2) bus2.req_addr = 32'(Depth - 1);
      else             bus2.req_addr = $urandom % Depth;
      bus2.req_wdata  = $urandom;
      bus2.resp_ready = ($urandom % 4) != 0;
    end
    @(posedge clk);
    #1;
    bus2.req_valid  = 1'b0;
    bus2.resp_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    check("drain_idle", 32'(bus2.req_ready), 32'd1);

    // Zero-latency build.
    req0(1'b1, 32'd3, 32'd5, lat, rd, err);
    check("l0_st_lat", 32'(lat), 32'd1);
    check("l0_st_rdata", rd, 32'd0);
    check("l0_st_err", 32'(err), 32'd0);
    req0(1'b0, 32'd3, 32'd0, lat, rd, err);
    check("l0_ld_lat", 32'(lat), 32'd1);
    check("l0_ld_rdata", rd, 32'd5);
    check("l0_ld_err", 32'(err), 32'd0);

    chk_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
